fixed_point_unit: RTL and testbench
===================================

// Module: fixed_point_unit
// PURPOSE
//  Multi-cycle fixed-point arithmetic unit for the core's FPU execute path.
//  Computes ADD, SUB, MUL and SQRT on Q(WIDTH-FBITS).FBITS two's-complement operands.
//  ADD/SUB are single-cycle; MUL and SQRT are iterative. A ready flag marks a valid result.
// PARAMETERS
//  WIDTH  32  operand/result width in bits
//  FBITS  10  fractional bits; value = raw / 2^FBITS
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-low reset
//  operand_1  in   WIDTH  first operand (radicand for SQRT)
//  operand_2  in   WIDTH  second operand (ignored for SQRT)
//  operation  in   2      `FPU_ADD=2'b00, `FPU_SUB=2'b01, `FPU_MUL=2'b10, `FPU_SQRT=2'b11 (Defines.vh)
//  result     out  WIDTH  fixed-point result, same Q format as the operands
//  ready      out  1      result valid for current operands/operation
// BEHAVIOUR
//  Reset (reset=0, async): FSM->IDLE, result=0, ready=0, all internal registers cleared.
//  ADD: result = operand_1 + operand_2, mod 2^WIDTH (wraps, no saturation). Combinational; ready=1.
//  SUB: result = operand_1 - operand_2, mod 2^WIDTH (wraps). Combinational; ready=1.
//  MUL:
//   - Signed 2*WIDTH product; result = product[WIDTH+FBITS-1:FBITS], truncated toward -inf.
//   - Upper overflow bits discarded.
//   - Implementation: take operand magnitudes, accumulate four 16x16 unsigned partial
//     products (one per cycle), then negate if the operand signs differ.
//  SQRT:
//   - operand_1 treated as unsigned. result = floor(sqrt(operand_1 * 2^FBITS)).
//   - Radicand is {operand_1, FBITS zeros}, WIDTH+FBITS = 42 bits.
//   - Restoring digit-by-digit algorithm; 2 result bits per cycle, 21 result bits total.
//   - Result is zero-extended to WIDTH.
//  FSM (MUL/SQRT only): IDLE -> BUSY -> DONE.
//   - IDLE: when operation is MUL or SQRT, latch operand_1, operand_2 and operation.
//     Go to BUSY. ready=0.
//   - BUSY: iterate; ready=0. Result is published when iteration completes.
//   - Latency from latch to DONE: MUL <= 5 cycles, SQRT <= 12 cycles (11 iterations + 1).
//   - DONE: ready=1 and result held stable.
//   - Any change of operand_1, operand_2 or operation vs the latched copy: drop ready
//     combinationally and return to IDLE next edge, which restarts the operation.
//  While in BUSY, input changes abort the operation and restart from IDLE on the next edge.
//  When operation switches to ADD/SUB, the FSM returns to IDLE; result and ready are combinational.
//  Reset asserted mid-operation aborts immediately; outputs go to reset values.
//  Divide-free; no exceptions/flags. Negative SQRT input is computed on its unsigned bit pattern.
// TESTING
//  1. Reset low then high -> result=0, ready=0 during reset; no X on outputs.
//  2. ADD 15.75 + 4.625 (raw 16128 + 4736) -> result=20864 (20.375), ready=1 same cycle.
//  3. SUB 4.625 - 15.75 -> result=-11392 (0xFFFFD380), ready=1.
//  4. MUL 15.75 * 4.625 (16128, 4736) -> ready within 6 cycles, result=74592 (72.84375).
//  5. SQRT 99.75 (raw 102144) -> ready within 13 cycles, result=10227 (0x27F3, ~9.9873).
//  6. Change operands while BUSY -> ready stays 0; fresh result computed for new operands.

Source files
------------

// File: rtl/fixed_point_unit.sv
// fixed_point_unit: Q(WIDTH-FBITS).FBITS arithmetic unit. ADD/SUB are combinational;
// MUL (four half-width partial products) and SQRT (restoring, 2 root bits/cycle) are iterative.
`default_nettype none

module fixed_point_unit #(
   parameter int WIDTH = 32,
   parameter int FBITS = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] operand_1,
   input  logic [WIDTH-1:0] operand_2,
   input  logic [1:0]       operation,
   output logic [WIDTH-1:0] result,
   output logic             ready
);

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_SUB  = 2'b01;
   localparam logic [1:0] OP_MUL  = 2'b10;
   localparam logic [1:0] OP_SQRT = 2'b11;

   localparam int HALF     = WIDTH / 2;
   localparam int PROD_W   = 2 * WIDTH;
   localparam int SQ_ITERS = (WIDTH + FBITS + 3) / 4;
   localparam int RT_W     = 2 * SQ_ITERS;
   localparam int PAD_W    = 2 * RT_W;
   localparam int REM_W    = RT_W + 3;
   localparam int CNT_W    = $clog2(SQ_ITERS + 1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

   state_t             state_q;
   logic [WIDTH-1:0]   op1_q, op2_q, amag_q, bmag_q, res_q;
   logic [1:0]         opn_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               neg_q;
   logic [PROD_W-1:0]  acc_q, acc_d, prod_d;
   logic [PAD_W-1:0]   rad_q, rad_d;
   logic [REM_W-1:0]   rem_q, rem_d;
   logic [RT_W-1:0]    root_q, root_d;
   logic [WIDTH-1:0]   mul_res_d;
   logic               changed_d;

   assign changed_d = (operand_1 != op1_q) || (operand_2 != op2_q) || (operation != opn_q);

   // Partial product cnt selects a-half by bit 0 and b-half by bit 1.
   always_comb begin
      logic [HALF-1:0]   a_sel, b_sel;
      logic [WIDTH-1:0]  pp;
      logic [PROD_W-1:0] pp_ext;
      a_sel  = cnt_q[0] ? amag_q[WIDTH-1:HALF] : amag_q[HALF-1:0];
      b_sel  = cnt_q[1] ? bmag_q[WIDTH-1:HALF] : bmag_q[HALF-1:0];
      pp     = a_sel * b_sel;
      pp_ext = {{WIDTH{1'b0}}, pp};
      case (cnt_q[1:0])
         2'd0:    acc_d = acc_q + pp_ext;
         2'd3:    acc_d = acc_q + (pp_ext << WIDTH);
         default: acc_d = acc_q + (pp_ext << HALF);
      endcase
      prod_d    = neg_q ? (~acc_d + 1'b1) : acc_d;
      mul_res_d = WIDTH'(prod_d >> FBITS);
   end

   always_comb begin
      logic [REM_W-1:0] trial;
      rem_d  = rem_q;
      root_d = root_q;
      rad_d  = rad_q;
      trial  = '0;
      for (int k = 0; k < 2; k++) begin
         rem_d = {rem_d[REM_W-3:0], rad_d[PAD_W-1 -: 2]};
         rad_d = rad_d << 2;
         trial = {{(REM_W-RT_W-2){1'b0}}, root_d, 2'b01};
         if (rem_d >= trial) begin
            rem_d  = rem_d - trial;
            root_d = {root_d[RT_W-2:0], 1'b1};
         end else begin
            root_d = {root_d[RT_W-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         op1_q   <= '0;
         op2_q   <= '0;
         opn_q   <= '0;
         amag_q  <= '0;
         bmag_q  <= '0;
         neg_q   <= 1'b0;
         cnt_q   <= '0;
         acc_q   <= '0;
         rad_q   <= '0;
         rem_q   <= '0;
         root_q  <= '0;
         res_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (operation == OP_MUL || operation == OP_SQRT) begin
                  op1_q   <= operand_1;
                  op2_q   <= operand_2;
                  opn_q   <= operation;
                  amag_q  <= operand_1[WIDTH-1] ? (~operand_1 + 1'b1) : operand_1;
                  bmag_q  <= operand_2[WIDTH-1] ? (~operand_2 + 1'b1) : operand_2;
                  neg_q   <= operand_1[WIDTH-1] ^ operand_2[WIDTH-1];
                  cnt_q   <= '0;
                  acc_q   <= '0;
                  rad_q   <= {{(PAD_W-WIDTH-FBITS){1'b0}}, operand_1, {FBITS{1'b0}}};
                  rem_q   <= '0;
                  root_q  <= '0;
                  state_q <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (changed_d) begin
                  state_q <= S_IDLE;
               end else if (opn_q == OP_MUL) begin
                  cnt_q <= cnt_q + 1'b1;
                  acc_q <= acc_d;
                  if (cnt_q == CNT_W'(3)) begin
                     res_q   <= mul_res_d;
                     state_q <= S_DONE;
                  end
               end else begin
                  cnt_q  <= cnt_q + 1'b1;
                  rem_q  <= rem_d;
                  root_q <= root_d;
                  rad_q  <= rad_d;
                  if (cnt_q == CNT_W'(SQ_ITERS - 1)) begin
                     res_q   <= {{(WIDTH-RT_W){1'b0}}, root_d};
                     state_q <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               if (changed_d) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Outputs are forced to zero while reset is held, even for the combinational ops.
   always_comb begin
      result = '0;
      ready  = 1'b0;
      if (reset) begin
         if (operation == OP_ADD) begin
            result = operand_1 + operand_2;
            ready  = 1'b1;
         end else if (operation == OP_SUB) begin
            result = operand_1 - operand_2;
            ready  = 1'b1;
         end else begin
            result = res_q;
            ready  = (state_q == S_DONE) && !changed_d;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fixed_point_unit.sv
// tb_fixed_point_unit: directed and randomized checks of fixed_point_unit against an arithmetic model.
`default_nettype none

module tb_fixed_point_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] operand_1 = '0;
   logic [31:0] operand_2 = '0;
   logic [1:0]  operation = 2'b00;
   logic [31:0] result;
   logic        ready;

   int n_total = 0;
   int n_pass  = 0;

   fixed_point_unit #(.WIDTH(32), .FBITS(10)) dut (
      .clk(clk), .reset(reset), .operand_1(operand_1), .operand_2(operand_2),
      .operation(operation), .result(result), .ready(ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] pa, pb, p;
      longint unsigned    x, lo, hi, mid;
      case (op)
         2'b00: return a + b;
         2'b01: return a - b;
         2'b10: begin
            pa = 64'($signed(a));
            pb = 64'($signed(b));
            p  = pa * pb;
            return 32'(p >>> 10);
         end
         default: begin
            x  = longint'(a) * 1024;
            lo = 0;
            hi = 64'd1 << 21;
            while (lo < hi) begin
               mid = (lo + hi + 1) / 2;
               if (mid * mid <= x) lo = mid;
               else hi = mid - 1;
            end
            return 32'(lo);
         end
      endcase
   endfunction

   task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
      logic [31:0] exp;
      int          limit, cyc;
      logic        got;
      @(negedge clk);
      operation = op;
      operand_1 = a;
      operand_2 = b;
      exp = model(op, a, b);
      if (op < 2'b10) begin
         #1;
         chk({tag, "_rdy"}, 32'(ready), 32'd1);
         chk(tag, result, exp);
      end else begin
         limit = (op == 2'b10) ? 6 : 13;
         cyc = 0;
         got = 1'b0;
         while (cyc < limit && !got) begin
            @(posedge clk);
            #1;
            cyc++;
            got = ready;
         end
         chk({tag, "_rdy"}, 32'(got), 32'd1);
         chk(tag, result, exp);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [1:0]  op;
      logic [31:0] a, b;

      operation = 2'b00;
      operand_1 = 32'd16128;
      operand_2 = 32'd4736;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_result", result, 32'd0);
      chk("reset_ready", 32'(ready), 32'd0);
      @(negedge clk);
      reset = 1'b1;

      run(2'b00, 32'd16128, 32'd4736, "add_dir");
      run(2'b01, 32'd4736, 32'd16128, "sub_dir");
      chk("sub_value", result, 32'hFFFFD380);
      run(2'b10, 32'd16128, 32'd4736, "mul_dir");
      chk("mul_value", result, 32'd74592);

      @(negedge clk);
      operand_1 = operand_1 ^ 32'd1;
      #1;
      chk("done_drop_rdy", 32'(ready), 32'd0);

      run(2'b11, 32'd102144, 32'd0, "sqrt_dir");
      chk("sqrt_value", result, 32'd10227);

      run(2'b00, 32'h7FFFFFFF, 32'd1, "add_wrap");
      run(2'b01, 32'h80000000, 32'd1, "sub_wrap");
      run(2'b10, 32'h80000000, 32'h80000000, "mul_minmin");
      run(2'b10, 32'hFFFFFC00, 32'd1, "mul_neg_trunc");
      run(2'b10, 32'hFFFFF000, 32'd5000, "mul_neg");
      run(2'b11, 32'hFFFFFFFF, 32'd0, "sqrt_max");
      run(2'b11, 32'd0, 32'd0, "sqrt_zero");

      @(negedge clk);
      operation = 2'b10;
      operand_1 = 32'd3000;
      operand_2 = 32'hFFFF0000;
      repeat (2) @(posedge clk);
      #1;
      chk("busy_rdy", 32'(ready), 32'd0);
      run(2'b10, 32'h00123456, 32'hFFFFABCD, "mul_abort");

      @(negedge clk);
      operation = 2'b11;
      operand_1 = 32'd555555;
      repeat (4) @(posedge clk);
      #1;
      chk("sqrt_busy_rdy", 32'(ready), 32'd0);
      run(2'b11, 32'd987654, 32'd0, "sqrt_abort");

      @(negedge clk);
      operation = 2'b11;
      operand_1 = 32'd40000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("midreset_result", result, 32'd0);
      chk("midreset_rdy", 32'(ready), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      run(2'b11, 32'd40000, 32'd0, "sqrt_after_reset");

      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = $urandom;
         b  = $urandom;
         if (i % 4 == 1) a = a >> $urandom_range(0, 24);
         if (i % 4 == 2) b = b >> $urandom_range(0, 24);
         run(op, a, b, $sformatf("rand%0d_op%0d", i, op));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
